modulo_gerenciador_buffers_rolhas_param: RTL and testbench

//   Parametrised cork-supply manager for the filling/sealing line. Holds the secondary (operator) and

---
 rtl/modulo_gerenciador_buffers_rolhas_param.sv | 135 +++++++++++++
 tb/tb_modulo_gerenciador_buffers_rolhas_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/modulo_gerenciador_buffers_rolhas_param.sv
// Cork-supply manager: secondary (operator) and principal (dispenser) buffers,
// operator load check, per-pulse consumption and batched auto-refill FSM.
// Optional feature macro: ROLHAS_TOTAL_CONSUMO_EN adds total_cons[15:0],
// a saturating count of successful consumes.
module modulo_gerenciador_buffers_rolhas_param #(
  parameter int W         = 7,
  parameter int SEC_MAX   = 99,
  parameter int PRI_MAX   = 99,
  parameter int MIN_LEVEL = 5,
  parameter int BATCH     = 20
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         enable,
  input  logic         load_valid,
  input  logic [W-1:0] load_qty,
  input  logic         consume,
  output logic         load_ack,
  output logic         load_rej,
  output logic         cons_err,
  output logic         xfer_busy,
  output logic         ro,
  output logic [W-1:0] buf_sec,
  output logic [W-1:0] buf_pri,
`ifdef ROLHAS_TOTAL_CONSUMO_EN
  output logic [15:0]  total_cons,
`endif
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [W:0]   C_SEC_MAX = (W+1)'(SEC_MAX);
  localparam logic [W:0]   C_PRI_MAX = (W+1)'(PRI_MAX);
  localparam logic [W:0]   C_MIN     = (W+1)'(MIN_LEVEL);
  localparam logic [W:0]   C_BATCH   = (W+1)'(BATCH);
  localparam logic [W-1:0] C_ONE     = W'(1);

  state_t       r_state;
  logic [W-1:0] r_sec;
  logic [W-1:0] r_pri;
  logic [W-1:0] r_cnt;
  logic         r_ack;
  logic         r_rej;
  logic         r_err;

  logic         w_step;
  logic [W:0]   w_sec_after;
  logic [W:0]   w_sec_sum;
  logic         w_accept;
  logic         w_cons_ok;
  logic         w_trigger;

  // Refill step, load acceptance and consume outcome for this edge.
  always_comb begin
    w_step      = (r_state == XFER) && enable;
    w_sec_after = {1'b0, r_sec} - {{W{1'b0}}, w_step};
    w_sec_sum   = w_sec_after + {1'b0, load_qty};
    w_accept    = load_valid && (load_qty != '0) && (w_sec_sum <= C_SEC_MAX);
    // A step landing on the same edge supplies the cork, so the consume always succeeds.
    w_cons_ok   = consume && (w_step || (r_pri != '0));
    w_trigger   = enable && ({1'b0, r_pri} <= C_MIN) && ({1'b0, r_sec} >= C_BATCH)
                  && (({1'b0, r_pri} + C_BATCH) <= C_PRI_MAX);
  end

  // Buffer counters, response pulses and refill FSM.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_sec   <= '0;
      r_pri   <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rej   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= w_accept;
      r_rej <= load_valid && !w_accept;
      r_err <= consume && !w_cons_ok;

      r_sec <= w_accept ? w_sec_sum[W-1:0] : w_sec_after[W-1:0];

      if (w_step && !consume)
        r_pri <= r_pri + C_ONE;
      else if (!w_step && w_cons_ok)
        r_pri <= r_pri - C_ONE;

      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state <= XFER;
            r_cnt   <= W'(BATCH);
          end
        end
        XFER: begin
          if (w_step) begin
            r_cnt <= r_cnt - C_ONE;
            if (r_cnt == C_ONE)
              r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ROLHAS_TOTAL_CONSUMO_EN
  logic [15:0] r_tot;

  // Saturating count of successful consumes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      r_tot <= '0;
    else if (w_cons_ok && (r_tot != 16'hFFFF))
      r_tot <= r_tot + 16'd1;
  end

  assign total_cons = r_tot;
`endif

  assign load_ack  = r_ack;
  assign load_rej  = r_rej;
  assign cons_err  = r_err;
  assign xfer_busy = (r_state == XFER);
  assign ro        = (r_pri == '0);
  assign buf_sec   = r_sec;
  assign buf_pri   = r_pri;
  assign state     = r_state;

endmodule

// File: tb/tb_modulo_gerenciador_buffers_rolhas_param.sv
// Scoreboard bench for the cork-supply manager: the driver applies one stimulus
// vector per cycle and pushes the reference model's expected post-edge view;
// a monitor pops and compares after every rising edge.
module tb_modulo_gerenciador_buffers_rolhas_param;

  localparam int W         = 7;
  localparam int SEC_MAX   = 99;
  localparam int PRI_MAX   = 99;
  localparam int MIN_LEVEL = 5;
  localparam int BATCH     = 20;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         enable = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_qty = '0;
  logic         consume = 1'b0;
  logic         load_ack, load_rej, cons_err, xfer_busy, ro;
  logic [W-1:0] buf_sec, buf_pri;
  logic [1:0]   state;
`ifdef ROLHAS_TOTAL_CONSUMO_EN
  logic [15:0]  total_cons;
`endif

  modulo_gerenciador_buffers_rolhas_param #(
    .W(W), .SEC_MAX(SEC_MAX), .PRI_MAX(PRI_MAX), .MIN_LEVEL(MIN_LEVEL), .BATCH(BATCH)
  ) dut (
    .clk(clk), .clr(clr), .enable(enable), .load_valid(load_valid),
    .load_qty(load_qty), .consume(consume), .load_ack(load_ack),
    .load_rej(load_rej), .cons_err(cons_err), .xfer_busy(xfer_busy),
    .ro(ro), .buf_sec(buf_sec), .buf_pri(buf_pri),
`ifdef ROLHAS_TOTAL_CONSUMO_EN
    .total_cons(total_cons),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec, pri, st, ack, rej, err, busy, ro, tot;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents, phase (0 idle, 1 moving, 2 done) and corks left in batch.
  int m_sec = 0, m_pri = 0, m_st = 0, m_left = 0, m_tot = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_sec = 0; m_pri = 0; m_st = 0; m_left = 0; m_tot = 0;
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the edge.
  task automatic cyc(input bit en, input bit lv, input int q, input bit cons);
    snap_t e;
    bit step, accept, cons_ok;
    @(negedge clk);
    enable = en; load_valid = lv; load_qty = W'(q); consume = cons;
    step    = (m_st == 1) && en;
    accept  = lv && (q != 0) && (m_sec - int'(step) + q <= SEC_MAX);
    cons_ok = cons && (step || m_pri > 0);
    e.ack = int'(accept);
    e.rej = int'(lv && !accept);
    e.err = int'(cons && !cons_ok);
    if (m_st == 0) begin
      if (en && m_pri <= MIN_LEVEL && m_sec >= BATCH && m_pri + BATCH <= PRI_MAX) begin
        m_st = 1; m_left = BATCH;
      end
    end else if (m_st == 1) begin
      if (step) begin
        m_left--;
        if (m_left == 0) m_st = 2;
      end
    end else begin
      m_st = 0;
    end
    m_sec = m_sec - int'(step) + (accept ? q : 0);
    m_pri = m_pri + int'(step) - int'(cons_ok);
    if (cons_ok && m_tot < 65535) m_tot++;
    e.sec = m_sec; e.pri = m_pri; e.st = m_st; e.tot = m_tot;
    e.busy = int'(m_st == 1);
    e.ro = int'(m_pri == 0);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sec"}, int'(buf_sec), 0);
    chk({tag, "_pri"}, int'(buf_pri), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_ack"}, int'(load_ack), 0);
    chk({tag, "_rej"}, int'(load_rej), 0);
    chk({tag, "_err"}, int'(cons_err), 0);
    chk({tag, "_busy"}, int'(xfer_busy), 0);
    chk({tag, "_ro"}, int'(ro), 1);
`ifdef ROLHAS_TOTAL_CONSUMO_EN
    chk({tag, "_tot"}, int'(total_cons), 0);
`endif
  endtask

  // Asynchronous clear between edges, checked immediately, then released before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    enable = 1'b0; load_valid = 1'b0; consume = 1'b0; load_qty = '0;
    #1 clr = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    #1 clr = 1'b1;
  endtask

  // Monitor: compare DUT against the oldest pending expectation after each rising edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("buf_sec", int'(buf_sec), e.sec);
        chk("buf_pri", int'(buf_pri), e.pri);
        chk("state", int'(state), e.st);
        chk("load_ack", int'(load_ack), e.ack);
        chk("load_rej", int'(load_rej), e.rej);
        chk("cons_err", int'(cons_err), e.err);
        chk("xfer_busy", int'(xfer_busy), e.busy);
        chk("ro", int'(ro), e.ro);
`ifdef ROLHAS_TOTAL_CONSUMO_EN
        chk("total_cons", int'(total_cons), e.tot);
`endif
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    int guard;
    #2 check_reset_outputs("por");
    do_reset("rst0");

    // Load 30, then the refill runs to completion.
    cyc(1, 1, 30, 0);
    for (int unsigned i = 0; i < 22; i++) cyc(1, 0, 0, 0);

    // Capacity and zero-quantity rejects, then fill exactly to capacity.
    cyc(1, 1, 80, 0);
    cyc(1, 1, 10, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 9, 0);
    cyc(1, 1, 1, 0);

    // Drain principal with refill disabled, then consume on empty.
    for (int unsigned i = 0; i < 20; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Start refill, consume during steps, pause, resume to completion.
    cyc(1, 0, 0, 0);
    for (int unsigned i = 0; i < 5; i++) cyc(1, 0, 0, 1);
    for (int unsigned i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 5, 0);
    for (int unsigned i = 0; i < 18; i++) cyc(1, 0, 0, 0);

    // Drain, re-enter refill and clear mid-batch.
    for (int unsigned i = 0; i < 16; i++) cyc(0, 0, 0, 1);
    guard = 0;
    while (m_st != 1 && guard < 30) begin
      cyc(1, 0, 0, 0);
      guard++;
    end
    chk("reach_xfer", m_st, 1);
    for (int unsigned i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    @(posedge clk); #2;
    do_reset("rst_mid");

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      int q;
      q = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (1 << W) - 1))
                                      : int'($urandom_range(0, 40));
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 6) == 0, q,
          $urandom_range(0, 4) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
